// File: rtl/imem_loader_if.sv
// imem_loader_if: word stream into the loader plus its byte write port.
// Signals: in_valid/in_data/in_ready (word stream), mem_we/mem_addr/mem_wdata (byte write).
interface imem_loader_if #(
    parameter int ADDR_W = 14
);
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    // master: boot/test source feeding words and observing the memory port
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // slave: the loader itself
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: splits 32-bit words into big-endian byte writes for the instruction memory.
// Ports: clk, rst_n (sync, active low), start/start_addr/word_count request,
//   bus (word stream in, byte write out), busy/cpu_hold status, done/err pulses.
module imem_loader #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    imem_loader_if.slave      bus,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    // wide enough to hold start_addr + 4*word_count without overflow
    localparam int EW = ((ADDR_W > CNT_W + 2) ? ADDR_W : CNT_W + 2) + 1;

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [CNT_W-1:0]  remaining, remaining_n;
    logic [1:0]        idx, idx_n;
    logic [31:0]       word, word_n;
    logic              we_n, ready_n, busy_n, done_n, err_n;
    logic [ADDR_W-1:0] maddr_n;
    logic [7:0]        wdata_n;
    logic [31:0]       shifted;
    logic [EW-1:0]     end_addr;
    logic              bad;

    assign end_addr = EW'(start_addr) + (EW'(word_count) << 2);
    assign bad      = (start_addr[1:0] != 2'b00) || (end_addr > (EW'(1) << ADDR_W));

    // Outputs are registered from next-state values so a byte appears on the
    // write port in the cycle right after its word is handshaken.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        idx_n       = idx;
        word_n      = word;
        we_n        = 1'b0;
        maddr_n     = bus.mem_addr;
        wdata_n     = bus.mem_wdata;
        err_n       = 1'b0;
        shifted     = word << {idx + 2'd1, 3'b000};
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (bad) begin
                        err_n = 1'b1;
                    end else if (word_count == '0) begin
                        state_n = FIN;
                    end else begin
                        addr_n      = start_addr;
                        remaining_n = word_count;
                        state_n     = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                if (bus.in_valid && bus.in_ready) begin
                    word_n  = bus.in_data;
                    idx_n   = 2'd0;
                    we_n    = 1'b1;
                    maddr_n = addr;
                    wdata_n = bus.in_data[31:24];
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (idx == 2'd3) begin
                    addr_n      = addr + ADDR_W'(4);
                    remaining_n = remaining - CNT_W'(1);
                    state_n     = (remaining == CNT_W'(1)) ? FIN : ACCEPT;
                end else begin
                    idx_n   = idx + 2'd1;
                    we_n    = 1'b1;
                    // addr is word-aligned, so the byte index fills the low bits
                    maddr_n = {addr[ADDR_W-1:2], idx + 2'd1};
                    wdata_n = shifted[31:24];
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        ready_n = (state_n == ACCEPT);
        busy_n  = (state_n == ACCEPT) || (state_n == WRITE);
        done_n  = (state_n == FIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            idx           <= '0;
            word          <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            busy          <= 1'b0;
            cpu_hold      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            remaining     <= remaining_n;
            idx           <= idx_n;
            word          <= word_n;
            bus.in_ready  <= ready_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= maddr_n;
            bus.mem_wdata <= wdata_n;
            busy          <= busy_n;
            cpu_hold      <= busy_n;
            done          <= done_n;
            err           <= err_n;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized checks of imem_loader against a
// byte-list model of big-endian word loading.
module tb_imem_loader;
    localparam int ADDR_W = 14;
    localparam int CNT_W  = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic              busy, cpu_hold, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int start_cyc = 0;
    int err_cnt = 0;
    int viol = 0;
    int busy_cnt = 0;
    int wa_q[$];
    int wd_q[$];
    int wc_q[$];
    int done_q[$];
    int hs_q[$];
    logic [31:0] ld_words[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the write port and status flags mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa_q.push_back(int'(bus.mem_addr));
            wd_q.push_back(int'(bus.mem_wdata));
            wc_q.push_back(cyc);
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if ((bus.in_ready && bus.mem_we) || (busy !== cpu_hold) || (bus.mem_we && !busy))
            viol <= viol + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_q.delete();
        hs_q.delete();
        err_cnt = 0;
        viol = 0;
        busy_cnt = 0;
    endtask

    // Expected writes: word k, byte b lands at sa+4k+b holding bits 31-8b..24-8b.
    function automatic int model_mism(input int sa);
        int m;
        m = 0;
        if (wa_q.size() != 4 * ld_words.size()) return 1000 + wa_q.size();
        foreach (ld_words[k]) begin
            for (int b = 0; b < 4; b++) begin
                if (wa_q[4*k+b] != sa + 4*k + b) m++;
                if (wd_q[4*k+b] != int'((ld_words[k] >> (24 - 8*b)) & 32'hff)) m++;
            end
        end
        return m;
    endfunction

    task automatic issue_start(input int sa, input int cnt);
        start = 1'b1;
        start_addr = ADDR_W'(sa);
        word_count = CNT_W'(cnt);
        start_cyc = cyc;
        step();
        start = 1'b0;
        start_addr = ADDR_W'($urandom);
        word_count = CNT_W'($urandom);
    endtask

    task automatic feed(input int gap, input bit rnd, input bit poke);
        int g;
        int t;
        for (int k = 0; k < ld_words.size(); k++) begin
            g = rnd ? int'($urandom_range(0, 3)) : gap;
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) begin
                n_total++;
                $display("FAIL feed_timeout in_ready=%b want 1", bus.in_ready);
                return;
            end
            repeat (g) step();
            if (poke && k == 0) begin
                start = 1'b1;
                start_addr = ADDR_W'(2);
                word_count = CNT_W'(1);
            end
            bus.in_valid = 1'b1;
            bus.in_data = ld_words[k];
            hs_q.push_back(cyc);
            step();
            start = 1'b0;
            bus.in_valid = 1'b0;
            bus.in_data = $urandom;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_q.size() == 0 && t < 40) begin
            step();
            t++;
        end
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_total++;
        if ({busy, cpu_hold, done, err, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0)
            $display("FAIL reset_outputs got %b want all 0",
                {busy, cpu_hold, done, err, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) step();
        n_total++;
        if ({busy, done, err, bus.in_ready, bus.mem_we} !== 5'b0)
            $display("FAIL idle_after_reset got %b want 0", {busy, done, err, bus.in_ready, bus.mem_we});
        else n_pass++;
    endtask

    task automatic test_single();
        int lat;
        clear();
        ld_words = '{32'h24130005};
        issue_start(200, 1);
        feed(0, 0, 0);
        wait_done();
        n_total++;
        if (model_mism(200) != 0) $display("FAIL single_writes mism=%0d want 0", model_mism(200));
        else n_pass++;
        lat = 0;
        foreach (wc_q[i]) if (wc_q[i] != hs_q[0] + 1 + i) lat++;
        n_total++;
        if (lat != 0 || wc_q.size() != 4) $display("FAIL single_latency bad=%0d n=%0d want 0/4", lat, wc_q.size());
        else n_pass++;
        n_total++;
        if (done_q.size() != 1 || done_q[0] != hs_q[0] + 5)
            $display("FAIL single_done n=%0d cyc=%0d want 1 at %0d", done_q.size(),
                done_q.size() > 0 ? done_q[0] : -1, hs_q[0] + 5);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || viol != 0) $display("FAIL single_busy busy=%b viol=%0d want 0/0", busy, viol);
        else n_pass++;
    endtask

    task automatic test_gaps();
        clear();
        ld_words = '{32'h0E74B020, 32'h0ED5B820};
        issue_start(600, 2);
        feed(3, 0, 0);
        wait_done();
        n_total++;
        if (model_mism(600) != 0) $display("FAIL gaps_writes mism=%0d want 0", model_mism(600));
        else n_pass++;
        n_total++;
        if (viol != 0 || done_q.size() != 1) $display("FAIL gaps_ready viol=%0d done=%0d want 0/1", viol, done_q.size());
        else n_pass++;
    endtask

    task automatic test_zero();
        clear();
        ld_words.delete();
        issue_start(100, 0);
        wait_done();
        n_total++;
        if (done_q.size() != 1 || done_q[0] - start_cyc < 1 || done_q[0] - start_cyc > 2)
            $display("FAIL zero_done n=%0d dt=%0d want 1 pulse at 1..2",
                done_q.size(), done_q.size() > 0 ? done_q[0] - start_cyc : -1);
        else n_pass++;
        n_total++;
        if (wa_q.size() != 0 || busy_cnt != 0) $display("FAIL zero_quiet we=%0d busy=%0d want 0/0", wa_q.size(), busy_cnt);
        else n_pass++;
    endtask

    task automatic test_reject();
        int sa_t[2] = '{16380, 102};
        int cnt_t[2] = '{2, 1};
        for (int i = 0; i < 2; i++) begin
            clear();
            issue_start(sa_t[i], cnt_t[i]);
            n_total++;
            if ({err, busy, bus.in_ready} !== 3'b100)
                $display("FAIL reject_%0d err/busy/ready=%b want 100", i, {err, busy, bus.in_ready});
            else n_pass++;
            repeat (3) step();
            n_total++;
            if (err_cnt != 1 || wa_q.size() != 0 || done_q.size() != 0 || bus.in_ready !== 1'b0)
                $display("FAIL reject_pulse_%0d errs=%0d we=%0d done=%0d want 1/0/0",
                    i, err_cnt, wa_q.size(), done_q.size());
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        clear();
        ld_words = '{32'hA1B2C3D4};
        issue_start(400, 1);
        bus.in_valid = 1'b1;
        bus.in_data = ld_words[0];
        step();
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        n_total++;
        if ({busy, cpu_hold, done, err, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0)
            $display("FAIL abort_outputs got %b want 0",
                {busy, cpu_hold, done, err, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) step();
        n_total++;
        if (wa_q.size() != 2 || wa_q[0] != 400 || wa_q[1] != 401 || wd_q[0] != 'hA1 || wd_q[1] != 'hB2
            || done_q.size() != 0)
            $display("FAIL abort_partial n=%0d done=%0d want 2 writes 400:a1 401:b2 no done",
                wa_q.size(), done_q.size());
        else n_pass++;
        clear();
        ld_words = '{32'h00C0FFEE};
        issue_start(400, 1);
        feed(0, 0, 0);
        wait_done();
        n_total++;
        if (model_mism(400) != 0 || done_q.size() != 1)
            $display("FAIL abort_reload mism=%0d done=%0d want 0/1", model_mism(400), done_q.size());
        else n_pass++;
    endtask

    task automatic test_busy_start();
        clear();
        ld_words = '{32'h11223344, 32'h55667788};
        issue_start(1000, 2);
        feed(1, 0, 1);
        wait_done();
        n_total++;
        if (model_mism(1000) != 0 || done_q.size() != 1 || err_cnt != 0)
            $display("FAIL busy_start mism=%0d done=%0d errs=%0d want 0/1/0",
                model_mism(1000), done_q.size(), err_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad;
        clear();
        ld_words = '{$urandom, $urandom, $urandom};
        issue_start(2048, 3);
        feed(0, 0, 0);
        wait_done();
        bad = 0;
        for (int i = 1; i < hs_q.size(); i++) if (hs_q[i] - hs_q[i-1] != 5) bad++;
        n_total++;
        if (bad != 0 || hs_q.size() != 3 || model_mism(2048) != 0)
            $display("FAIL back_to_back spacing_bad=%0d hs=%0d mism=%0d want 0/3/0",
                bad, hs_q.size(), model_mism(2048));
        else n_pass++;
    endtask

    task automatic test_random();
        int sa;
        int cnt;
        bit exp_err;
        for (int it = 0; it < 12; it++) begin
            clear();
            sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(16300, DEPTH - 1))
                                             : int'($urandom_range(0, 8000));
            if ($urandom_range(0, 3) != 0) sa = sa & ~3;
            cnt = int'($urandom_range(0, 24));
            exp_err = (sa % 4 != 0) || (sa + 4 * cnt > DEPTH);
            ld_words.delete();
            for (int k = 0; k < cnt; k++) ld_words.push_back($urandom);
            issue_start(sa, cnt);
            if (exp_err) begin
                repeat (3) step();
                n_total++;
                if (err_cnt != 1 || wa_q.size() != 0 || done_q.size() != 0)
                    $display("FAIL rand_%0d_reject sa=%0d cnt=%0d errs=%0d we=%0d want 1/0",
                        it, sa, cnt, err_cnt, wa_q.size());
                else n_pass++;
            end else begin
                feed(0, 1, 0);
                wait_done();
                n_total++;
                if (model_mism(sa) != 0 || done_q.size() != 1 || err_cnt != 0 || viol != 0)
                    $display("FAIL rand_%0d_load sa=%0d cnt=%0d mism=%0d done=%0d errs=%0d viol=%0d",
                        it, sa, cnt, model_mism(sa), done_q.size(), err_cnt, viol);
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        test_reset();
        test_single();
        test_gaps();
        test_zero();
        test_reject();
        test_abort();
        test_busy_start();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
